// File: rtl/cpu_pkg.sv
// Types and constants shared by the pipeline stages of the MIPS CPU.
// The all-zero IF/ID bundle is the pipeline bubble: valid 0 and instr NOP.
package cpu_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with async reset, hold (stall) and bubble load.
// A bubble loads all zeros and takes priority over hold, so a flush always wins.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH = IF_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory addressing and the IF/ID register.
// Build option DELAY_SLOT_EN keeps the word fetched alongside a taken redirect (delay slot).
//
// state | meaning
// RUN   | fetching; PC advances or is redirected each unstalled cycle
// HALT  | PC left instruction memory; IF/ID holds a bubble until reset
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IM_WORDS = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [31:0]                 redirect_pc,
    output logic [$clog2(IM_WORDS)-1:0] im_addr,
    input  logic [31:0]                 im_rdata,
    output logic                        if_id_valid,
    output logic [31:0]                 if_id_instr,
    output logic [31:0]                 if_id_pc,
    output logic [31:0]                 if_id_pc8,
    output logic                        halted
);

    localparam int AW = $clog2(IM_WORDS);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  word_idx;
    logic         in_range;
    logic         ifid_hold;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // Full 32-bit word index, so addresses past the memory or below the base never alias.
    assign word_idx = (pc - RESET_PC) >> 2;
    assign in_range = (pc[1:0] == 2'b00) && (pc >= RESET_PC) && (word_idx < 32'(IM_WORDS));
    assign im_addr  = word_idx[AW-1:0];
    assign halted   = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ifid_hold    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_d.valid = 1'b1;
        ifid_d.instr = im_rdata;
        ifid_d.pc    = pc;
        ifid_d.pc8   = pc + 32'd8;
        case (state)
            RUN: begin
                if (!in_range) begin
                    state_nxt   = HALT;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    // The redirecting instruction is itself stalled in ID, so redirect waits too.
                    ifid_hold = 1'b1;
                end else begin
                    pc_nxt = redirect ? redirect_pc : pc + 32'd4;
`ifdef DELAY_SLOT_EN
                    ifid_bubble = 1'b0;
`else
                    ifid_bubble = redirect;
`endif
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                ifid_bubble = 1'b1;
            end
        endcase
    end

    if_id_reg #(
        .WIDTH (IF_ID_W)
    ) u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign if_id_valid = ifid_q.valid;
    assign if_id_instr = ifid_q.instr;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_pc8   = ifid_q.pc8;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, random run against a reference model,
// and a small-memory instance for the run-off-the-end halt.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int          W   = 1024;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] rpc;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic        valid, halted;
    logic [31:0] instr, ipc, ipc8;

    logic        reset2, stall2, redirect2;
    logic [31:0] rpc2;
    logic [1:0]  im_addr2;
    logic [31:0] im_rdata2;
    logic        valid2, halted2;
    logic [31:0] instr2, ipc2, ipc82;

    logic [31:0] mem [W];

    assign im_rdata  = mem[im_addr];
    assign im_rdata2 = mem[im_addr2];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC), .IM_WORDS(W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(rpc),
        .im_addr(im_addr), .im_rdata(im_rdata), .if_id_valid(valid), .if_id_instr(instr),
        .if_id_pc(ipc), .if_id_pc8(ipc8), .halted(halted)
    );

    fetch_stage #(.RESET_PC(RPC), .IM_WORDS(4)) dut_small (
        .clk(clk), .reset(reset2), .stall(stall2), .redirect(redirect2), .redirect_pc(rpc2),
        .im_addr(im_addr2), .im_rdata(im_rdata2), .if_id_valid(valid2), .if_id_instr(instr2),
        .if_id_pc(ipc2), .if_id_pc8(ipc82), .halted(halted2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: PC, halt flag and expected IF/ID contents.
    logic [31:0] m_pc, m_instr, m_ipc, m_pc8;
    logic        m_halt, m_valid;

    function automatic bit fetchable(input logic [31:0] p, input int words);
        return (p[1:0] == 2'b00) && (p >= RPC) && (((p - RPC) >> 2) < 32'(words));
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_pc8 = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rp);
        if (!m_halt) begin
            if (!fetchable(m_pc, W)) begin
                m_halt = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
            end else if (!s) begin
                if (r && !DS) begin
                    m_valid = 1'b0; m_instr = 32'h0;
                end else begin
                    m_valid = 1'b1;
                    m_instr = mem[int'((m_pc - RPC) >> 2)];
                    m_ipc   = m_pc;
                    m_pc8   = m_pc + 32'd8;
                end
                m_pc = r ? rp : m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model(input int cyc);
        chk($sformatf("rnd%0d.valid", cyc), {31'd0, valid}, {31'd0, m_valid});
        chk($sformatf("rnd%0d.instr", cyc), instr, m_instr);
        chk($sformatf("rnd%0d.halted", cyc), {31'd0, halted}, {31'd0, m_halt});
        chk($sformatf("rnd%0d.im_addr", cyc), {22'd0, im_addr}, ((m_pc - RPC) >> 2) & 32'h3FF);
        if (m_valid) begin
            chk($sformatf("rnd%0d.pc", cyc), ipc, m_ipc);
            chk($sformatf("rnd%0d.pc8", cyc), ipc8, m_pc8);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [9:0]  addr;
        logic        halted;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic        s, r;
        logic [31:0] rp;
        int          halt_cnt;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = 32'h0;
        reset2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; rpc2 = 32'h0;
        for (int k = 0; k < W; k++) mem[k] = 32'h1000_0000 + k;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1000_0000, 32'h3000, 10'h001, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1000_0001, 32'h3004, 10'h002, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h1000_0001, 32'h3004, 10'h002, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h1000_0001, 32'h3004, 10'h002, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,    1'b1, 32'h1000_0001, 32'h3004, 10'h002, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1000_0002, 32'h3008, 10'h003, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h3100, DS, DS ? 32'h1000_0003 : 32'h0, 32'h300C, 10'h040, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1000_0040, 32'h3100, 10'h041, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h3200, 1'b1, 32'h1000_0040, 32'h3100, 10'h041, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'h3200, DS, DS ? 32'h1000_0041 : 32'h0, 32'h3104, 10'h080, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h1000_0080, 32'h3200, 10'h081, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h3102, DS, DS ? 32'h1000_0081 : 32'h0, 32'h3204, 10'h040, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,         32'h0,    10'h040, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 32'h3000, 1'b0, 32'h0,         32'h0,    10'h040, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,         32'h0,    10'h040, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'd0, valid}, 32'd0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.pc", ipc, 32'h0);
        chk("rst.pc8", ipc8, 32'h0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.im_addr", {22'd0, im_addr}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            stall = tbl[i].stall; redirect = tbl[i].redirect; rpc = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d.instr", i), instr, tbl[i].instr);
            chk($sformatf("tbl%0d.im_addr", i), {22'd0, im_addr}, {22'd0, tbl[i].addr});
            chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].halted});
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d.pc", i), ipc, tbl[i].pc);
                chk($sformatf("tbl%0d.pc8", i), ipc8, tbl[i].pc + 32'd8);
            end
        end

        // Asynchronous reset from HALT, mid-cycle.
        for (int k = 0; k < W; k++) mem[k] = $urandom;
        stall = 1'b0; redirect = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst.halted", {31'd0, halted}, 32'd0);
        chk("arst.valid", {31'd0, valid}, 32'd0);
        chk("arst.instr", instr, 32'h0);
        chk("arst.pc", ipc, 32'h0);
        chk("arst.pc8", ipc8, 32'h0);
        chk("arst.im_addr", {22'd0, im_addr}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        halt_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 9))
                0:       rp = RPC + ($urandom_range(0, 1023) << 2) + $urandom_range(1, 3);
                1:       rp = RPC + 32'd4096 + ($urandom_range(0, 255) << 2);
                2:       rp = RPC - 32'd4;
                3:       rp = 32'hFFFF_FFFC;
                default: rp = RPC + ($urandom_range(0, 1023) << 2);
            endcase
            stall = s; redirect = r; rpc = rp;
            model_step(s, r, rp);
            @(posedge clk);
            #1;
            check_model(c);
            if (m_halt) halt_cnt++;
            if (halt_cnt >= 3) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                model_reset();
                halt_cnt = 0;
                check_model(c);
            end
        end
        stall = 1'b0; redirect = 1'b0;

        // Four-word memory: fetch runs off the end and halts permanently.
        reset2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("small%0d.valid", k), {31'd0, valid2}, 32'd1);
            chk($sformatf("small%0d.pc", k), ipc2, RPC + 32'(4 * k));
            chk($sformatf("small%0d.pc8", k), ipc82, RPC + 32'(4 * k) + 32'd8);
            chk($sformatf("small%0d.instr", k), instr2, mem[k]);
            chk($sformatf("small%0d.halted", k), {31'd0, halted2}, 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("smallh%0d.halted", k), {31'd0, halted2}, 32'd1);
            chk($sformatf("smallh%0d.valid", k), {31'd0, valid2}, 32'd0);
            chk($sformatf("smallh%0d.instr", k), instr2, 32'h0);
        end
        reset2 = 1'b1;
        #1;
        chk("small_rst.halted", {31'd0, halted2}, 32'd0);
        chk("small_rst.valid", {31'd0, valid2}, 32'd0);
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        @(posedge clk);
        #1;
        chk("small_restart.valid", {31'd0, valid2}, 32'd1);
        chk("small_restart.pc", ipc2, RPC);
        chk("small_restart.instr", instr2, mem[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
